// File: rtl/serial_frame_rx_pkg.sv
// Shared types and sizing helpers for the serial frame receiver.
package serial_frame_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } rx_state_t;

   // Clock counter runs 0..CLKS_PER_BIT-1 within one bit period.
   function automatic int clk_cnt_width(input int clks_per_bit);
      return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
   endfunction

   function automatic int bit_cnt_width(input int num_bits);
      return $clog2(num_bits + 1);
   endfunction

endpackage

// File: rtl/serial_frame_rx_flex_stp_sr.sv
// Serial-to-parallel shift register; direction selects which end the new sample enters.
module flex_stp_sr
   import serial_frame_rx_pkg::*;
#(
   parameter int NUM_BITS  = 8,
   parameter bit SHIFT_MSB = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                shift_enable,
   input  logic                serial_in,
   output logic [NUM_BITS-1:0] parallel_out
);

   logic [NUM_BITS-1:0] shift_reg;
   logic [NUM_BITS-1:0] shift_next;

   generate
      if (SHIFT_MSB) begin : g_msb_first
         assign shift_next = {shift_reg[NUM_BITS-2:0], serial_in};
      end else begin : g_lsb_first
         assign shift_next = {serial_in, shift_reg[NUM_BITS-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg <= '0;
      end else if (shift_enable) begin
         shift_reg <= shift_next;
      end
   end

   assign parallel_out = shift_reg;

endmodule

// File: rtl/serial_frame_rx.sv
// Oversampling serial frame receiver with valid/ready output port.
// Optional even parity bit is enabled by defining SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx
   import serial_frame_rx_pkg::*;
#(
   parameter int NUM_BITS     = 8,
   parameter bit SHIFT_MSB    = 1'b0,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                serial_in,
   output logic [NUM_BITS-1:0] rx_data,
   output logic                rx_valid,
   input  logic                rx_ready,
   output logic                framing_error,
   output logic                overrun,
   output logic                parity_error
);

   localparam int CW = clk_cnt_width(CLKS_PER_BIT);
   localparam int BW = bit_cnt_width(NUM_BITS);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BITS_LAST = BW'(NUM_BITS - 1);

   rx_state_t           state_reg;
   logic [CW-1:0]       clk_cnt_reg;
   logic [BW-1:0]       bit_cnt_reg;
   logic                sync_reg;
   logic                s_in;
   logic [NUM_BITS-1:0] rx_data_reg;
   logic                rx_valid_reg;
   logic                framing_error_reg;
   logic                overrun_reg;
   logic                shift_enable;
   logic [NUM_BITS-1:0] shift_word;
   logic                mid_bit;

   assign mid_bit      = (clk_cnt_reg == BIT_LAST);
   assign shift_enable = (state_reg == DATA) && mid_bit;

   flex_stp_sr #(
      .NUM_BITS (NUM_BITS),
      .SHIFT_MSB(SHIFT_MSB)
   ) u_shift (
      .clk         (clk),
      .rst         (rst),
      .shift_enable(shift_enable),
      .serial_in   (s_in),
      .parallel_out(shift_word)
   );

`ifdef SERIAL_FRAME_RX_PARITY_EN
   // Running XOR of data and parity bit: 1 at stop time means even parity failed.
   logic parity_acc_reg;
   logic parity_error_reg;
   assign parity_error = parity_error_reg;
`else
   assign parity_error = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= IDLE;
         clk_cnt_reg       <= '0;
         bit_cnt_reg       <= '0;
         sync_reg          <= 1'b1;
         s_in              <= 1'b1;
         rx_data_reg       <= '0;
         rx_valid_reg      <= 1'b0;
         framing_error_reg <= 1'b0;
         overrun_reg       <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
         parity_acc_reg    <= 1'b0;
         parity_error_reg  <= 1'b0;
`endif
      end else begin
         sync_reg          <= serial_in;
         s_in              <= sync_reg;
         framing_error_reg <= 1'b0;
         overrun_reg       <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
         parity_error_reg  <= 1'b0;
`endif
         // Consumption; a completion in the same cycle re-asserts valid below.
         if (rx_valid_reg && rx_ready) begin
            rx_valid_reg <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               clk_cnt_reg <= '0;
               bit_cnt_reg <= '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
               parity_acc_reg <= 1'b0;
`endif
               if (!s_in) begin
                  state_reg <= START;
               end
            end
            START: begin
               if (clk_cnt_reg == HALF_LAST) begin
                  clk_cnt_reg <= '0;
                  state_reg   <= s_in ? IDLE : DATA;
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CW'(1);
               end
            end
            DATA: begin
               if (mid_bit) begin
                  clk_cnt_reg <= '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                  parity_acc_reg <= parity_acc_reg ^ s_in;
`endif
                  if (bit_cnt_reg == BITS_LAST) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                     state_reg <= PARITY;
`else
                     state_reg <= STOP;
`endif
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + BW'(1);
                  end
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CW'(1);
               end
            end
`ifdef SERIAL_FRAME_RX_PARITY_EN
            PARITY: begin
               if (mid_bit) begin
                  clk_cnt_reg    <= '0;
                  parity_acc_reg <= parity_acc_reg ^ s_in;
                  state_reg      <= STOP;
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CW'(1);
               end
            end
`endif
            STOP: begin
               if (mid_bit) begin
                  clk_cnt_reg <= '0;
                  if (s_in) begin
                     state_reg <= IDLE;
                     if (!rx_valid_reg || rx_ready) begin
                        rx_data_reg  <= shift_word;
                        rx_valid_reg <= 1'b1;
                     end else begin
                        overrun_reg <= 1'b1;
                     end
`ifdef SERIAL_FRAME_RX_PARITY_EN
                     parity_error_reg <= parity_acc_reg;
`endif
                  end else begin
                     framing_error_reg <= 1'b1;
                     state_reg         <= BREAK;
                  end
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CW'(1);
               end
            end
            BREAK: begin
               // A line held low must return high before a new start is accepted.
               if (s_in) begin
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign rx_data       = rx_data_reg;
   assign rx_valid      = rx_valid_reg;
   assign framing_error = framing_error_reg;
   assign overrun       = overrun_reg;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: random and directed frames against a frame-level model.
module tb_serial_frame_rx;

   localparam int NB  = 8;
   localparam int CPB = 16;
   localparam bit SM  = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int LAT = 2 + (NB + 1) * CPB + CPB / 2 + 1 + PAR * CPB;

   localparam logic [1:0] EV_WORD  = 2'd0;
   localparam logic [1:0] EV_FRAME = 2'd1;
   localparam logic [1:0] EV_OVR   = 2'd2;
   localparam logic [1:0] EV_PAR   = 2'd3;

   typedef struct packed {
      logic [1:0]    kind;
      logic [NB-1:0] data;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          serial_in = 1'b1;
   logic          rx_ready = 1'b1;
   logic [NB-1:0] rx_data;
   logic          rx_valid;
   logic          framing_error;
   logic          overrun;
   logic          parity_error;

   int  total = 0;
   int  bad = 0;
   int  cyc = 0;
   int  last_word_cyc = -1;
   bit  pending = 1'b0;
   ev_t exp_q[$];

   logic          prev_valid = 1'b0;
   logic          prev_hs = 1'b0;
   logic          new_word;
   logic [NB-1:0] held_exp = '0;

   serial_frame_rx #(
      .NUM_BITS    (NB),
      .SHIFT_MSB   (SM),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .serial_in    (serial_in),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .framing_error(framing_error),
      .overrun      (overrun),
      .parity_error (parity_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic pop_check(input logic [1:0] kind, input logic [NB-1:0] data);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event: got kind=%0d data=%0h, required nothing (cycle %0d)",
                  kind, data, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind !== kind || (kind == EV_WORD && e.data !== data)) begin
            bad++;
            $display("FAIL event: got kind=%0d data=%0h, required kind=%0d data=%0h (cycle %0d)",
                     kind, data, e.kind, e.data, cyc);
         end else begin
            $display("event kind=%0d data=%0h at cycle %0d", kind, data, cyc);
         end
      end
   endtask

   // Monitor: decoupled from stimulus, consumes expected events as the DUT presents them.
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
         prev_hs    = 1'b0;
      end else begin
         new_word = rx_valid && (!prev_valid || prev_hs);
         if (new_word) begin
            if (exp_q.size() > 0 && exp_q[0].kind == EV_WORD) held_exp = exp_q[0].data;
            pop_check(EV_WORD, rx_data);
            last_word_cyc = cyc;
         end else if (rx_valid) begin
            check("rx_data_hold", rx_data, held_exp);
         end
         if (framing_error) pop_check(EV_FRAME, rx_data);
         if (overrun)       pop_check(EV_OVR, rx_data);
         if (parity_error)  pop_check(EV_PAR, rx_data);
         prev_valid = rx_valid;
         prev_hs    = rx_valid && rx_ready;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_ready(input logic b);
      rx_ready = b;
      if (b) pending = 1'b0;
   endtask

   task automatic drive_bit(input logic b);
      serial_in = b;
      tick(CPB);
   endtask

   // Model: outcome of one frame from its contents and the consumer's state.
   task automatic send_frame(input logic [NB-1:0] d, input logic stop, input logic par,
                             input int hold_low, output int start_cyc);
      if (!stop) begin
         exp_q.push_back({EV_FRAME, d});
      end else begin
         if (pending) begin
            exp_q.push_back({EV_OVR, d});
         end else begin
            exp_q.push_back({EV_WORD, d});
            if (!rx_ready) pending = 1'b1;
         end
         if (PAR != 0 && par != ^d) exp_q.push_back({EV_PAR, d});
      end
      $display("frame data=%0h stop=%0d par=%0d ready=%0d at cycle %0d", d, stop, par, rx_ready, cyc);
      start_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < NB; i++) drive_bit(SM ? d[NB-1-i] : d[i]);
      if (PAR != 0) drive_bit(par);
      drive_bit(stop);
      if (!stop) begin
         serial_in = 1'b0;
         tick(hold_low);
         serial_in = 1'b1;
         tick(4);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      logic [NB-1:0] d;
      logic stop;
      logic par;

      tick(3);
      check("reset_rx_valid", rx_valid, 0);
      check("reset_rx_data", rx_data, 0);
      check("reset_framing", framing_error, 0);
      check("reset_overrun", overrun, 0);
      check("reset_parity", parity_error, 0);
      rst = 1'b0;
      tick(5);

      // Single frame, latency from start edge to rx_valid
      set_ready(1'b1);
      d = 8'hA5;
      send_frame(d, 1'b1, ^d, 0, st);
      tick(2);
      check("latency", last_word_cyc - st, LAT);

      // Start-bit glitch is rejected, then a normal frame
      serial_in = 1'b0;
      tick(5);
      serial_in = 1'b1;
      tick(30);
      check("glitch_no_valid", rx_valid, 0);
      d = 8'h5A;
      send_frame(d, 1'b1, ^d, 0, st);
      tick(3);

      // Overrun: first word unconsumed when the second completes
      set_ready(1'b0);
      d = 8'h3C;
      send_frame(d, 1'b1, ^d, 0, st);
      d = 8'h81;
      send_frame(d, 1'b1, ^d, 0, st);
      tick(2);
      check("overrun_data_kept", rx_data, 8'h3C);
      check("overrun_valid_kept", rx_valid, 1);
      set_ready(1'b1);
      tick(2);
      check("consumed_valid_low", rx_valid, 0);

      // Framing error with a held-low line, then recovery
      d = 8'h55;
      send_frame(d, 1'b0, ^d, 64, st);
      check("framing_no_valid", rx_valid, 0);
      d = 8'h12;
      send_frame(d, 1'b1, ^d, 0, st);
      tick(3);
      check("after_break_data", rx_data, 8'h12);

      // Reset in the middle of the data bits
      serial_in = 1'b0;
      tick(CPB);
      serial_in = 1'b1;
      tick(3 * CPB);
      rst = 1'b1;
      tick(1);
      check("midrst_rx_valid", rx_valid, 0);
      check("midrst_rx_data", rx_data, 0);
      check("midrst_pulses", {framing_error, overrun, parity_error}, 0);
      rst = 1'b0;
      tick(40);
      d = 8'h0F;
      send_frame(d, 1'b1, ^d, 0, st);
      tick(3);
      check("after_rst_data", rx_data, 8'h0F);

`ifdef SERIAL_FRAME_RX_PARITY_EN
      // Bad parity: word still delivered, parity_error pulses
      d = 8'h07;
      send_frame(d, 1'b1, 1'b0, 0, st);
      tick(3);
      check("parity_word", rx_data, 8'h07);
`endif

      // Randomized frames: data, consumer readiness, stop/parity faults, gaps
      for (int n = 0; n < 14; n++) begin
         set_ready($urandom_range(0, 3) != 0);
         d    = NB'($urandom);
         stop = ($urandom_range(0, 6) != 0);
         par  = (^d) ^ ($urandom_range(0, 4) == 0);
         tick($urandom_range(0, 12));
         send_frame(d, stop, par, $urandom_range(0, 40), st);
      end

      set_ready(1'b1);
      tick(3 * CPB);
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
